// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner_if
// Description : Bundle of the 4x4 keypad matrix lines and decoded-key outputs
//               of keypad_scanner.
//   row_i       4  keypad rows, active-low, asynchronous to clk
//   col_o       4  column strobes, active-low, one-cold
//   key_code_o  4  code of the last accepted key
//   key_valid_o 1  single-cycle pulse: key_code_o is new this cycle
//   key_held_o  1  accepted key still debounced-pressed
//   Modports: slave  = scanner side (drives columns and key outputs)
//             master = board/consumer side (drives rows, reads the rest)
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_code_o;
  logic       key_valid_o;
  logic       key_held_o;

  modport slave (
    input  row_i,
    output col_o,
    output key_code_o,
    output key_valid_o,
    output key_held_o
  );

  modport master (
    output row_i,
    input  col_o,
    input  key_code_o,
    input  key_valid_o,
    input  key_held_o
  );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Scans a 4x4 matrix keypad one column at a time, debounces over
//               whole scans and decodes a single pressed key into a 4-bit
//               code used to preset the stopwatch time.
//   clk   1  system clock (raw board clock)
//   rst   1  asynchronous active-high reset
//   kp       keypad_scanner_if.slave (rows in; columns, key_code, key_valid,
//            key_held out)
// Options     : define KEYPAD_REPEAT_EN to enable auto-repeat while a key is
//               held (REPEAT_DELAY / REPEAT_RATE, counted in full scans).
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input wire               clk,
  input wire               rst,
  keypad_scanner_if.slave  kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  // Elaboration-time sanity check of the configuration.
  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scanner: SCAN_DIV must be >= 4 and the scan counts >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  // Matrix position (row*4+col) to key code.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:  code = 4'h1;  4'd1:  code = 4'h2;  4'd2:  code = 4'h3;  4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;  4'd5:  code = 4'h5;  4'd6:  code = 4'h6;  4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;  4'd9:  code = 4'h8;  4'd10: code = 4'h9;  4'd11: code = 4'hC;
      4'd12: code = 4'hE;  4'd13: code = 4'h0;  4'd14: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // ---------------------------------------------------------------- scanning
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic [3:0]       col_out_q;
  logic [3:0]       row_meta_q;
  logic [3:0]       row_sync_q;
  logic [1:0]       low_cnt_q, low_cnt_d;   // low bits seen this scan, saturates at 2
  logic [3:0]       low_idx_q, low_idx_d;   // position of the first low bit seen

  logic             slot_end;
  logic             scan_end;
  logic [2:0]       row_lows;
  logic [1:0]       row_pos;
  logic [2:0]       total;
  logic             scan_none;
  logic             scan_single;
  logic [3:0]       scan_idx;

  assign slot_end = (div_q == C_DIV_LAST);
  assign scan_end = slot_end && (col_q == 2'd3);

  always_comb begin
    row_lows = 3'd0;
    row_pos  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_q[r]) begin
        row_lows = row_lows + 3'd1;
        row_pos  = 2'(r);
      end
    end
    // Only meaningful on slot_end; at scan_end it includes the column-3 sample.
    total       = {1'b0, low_cnt_q} + row_lows;
    scan_none   = (total == 3'd0);
    scan_single = (total == 3'd1);
    scan_idx    = (low_cnt_q == 2'd1) ? low_idx_q : {row_pos, col_q};

    low_cnt_d = low_cnt_q;
    low_idx_d = low_idx_q;
    if (scan_end) begin
      low_cnt_d = 2'd0;
      low_idx_d = 4'd0;
    end else if (slot_end) begin
      low_cnt_d = (total >= 3'd2) ? 2'd2 : total[1:0];
      if (low_cnt_q == 2'd0 && row_lows == 3'd1) begin
        low_idx_d = {row_pos, col_q};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      col_q      <= 2'd0;
      col_out_q  <= 4'b1110;
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      low_cnt_q  <= 2'd0;
      low_idx_q  <= 4'd0;
    end else begin
      row_meta_q <= kp.row_i;
      row_sync_q <= row_meta_q;
      low_cnt_q  <= low_cnt_d;
      low_idx_q  <= low_idx_d;
      if (slot_end) begin
        div_q     <= '0;
        col_q     <= col_q + 2'd1;
        col_out_q <= {col_out_q[2:0], col_out_q[3]};
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  // ------------------------------------------------------- debounce / decode
  state_t           state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rcnt_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] C_DLY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] C_RATE_LAST = REP_W'(REPEAT_RATE - 1);

  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_armed_q;   // first repeat already issued
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
`endif
    end else begin
      key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      // Repeat timing restarts from zero on every new acceptance.
      if (state_q != ST_PRESSED) begin
        rep_cnt_q   <= '0;
        rep_armed_q <= 1'b0;
      end
`endif
      if (scan_end) begin
        case (state_q)
          ST_IDLE: begin
            if (scan_single) begin
              cand_q <= scan_idx;
              if (DEBOUNCE_SCANS <= 1) begin
                state_q     <= ST_PRESSED;
                rcnt_q      <= '0;
                key_code_q  <= key_map(scan_idx);
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                state_q <= ST_DEBOUNCE;
                cnt_q   <= C_CNT_ONE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (scan_single && scan_idx == cand_q) begin
              if (cnt_q == C_DEB_LAST) begin
                state_q     <= ST_PRESSED;
                cnt_q       <= '0;
                rcnt_q      <= '0;
                key_code_q  <= key_map(cand_q);
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_q + C_CNT_ONE;
              end
            end else begin
              // A different key restarts from IDLE instead of being adopted.
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end
          end
          ST_PRESSED: begin
            if (scan_none) begin
              if (rcnt_q == C_DEB_LAST) begin
                state_q    <= ST_IDLE;
                rcnt_q     <= '0;
                key_held_q <= 1'b0;
              end else begin
                rcnt_q <= rcnt_q + C_CNT_ONE;
              end
            end else begin
              // Multi-key scans also count as "still held".
              rcnt_q <= '0;
`ifdef KEYPAD_REPEAT_EN
              if ((!rep_armed_q && rep_cnt_q == C_DLY_LAST) ||
                  ( rep_armed_q && rep_cnt_q == C_RATE_LAST)) begin
                key_valid_q <= 1'b1;
                rep_cnt_q   <= '0;
                rep_armed_q <= 1'b1;
              end else begin
                rep_cnt_q <= rep_cnt_q + REP_W'(1);
              end
`endif
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign kp.col_o       = col_out_q;
  assign kp.key_code_o  = key_code_q;
  assign kp.key_valid_o = key_valid_q;
  assign kp.key_held_o  = key_held_q;

endmodule
`default_nettype wire
